serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 152 +++++++++++++++
 tb/tb_serial_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice built from two half_adder
// cells per cycle, with a carry flip-flop linking consecutive bits.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  // One-hot encoding so ready/busy/done are direct register bits.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   a_sr_r;
  logic [WIDTH-1:0]   b_sr_r;
  logic [WIDTH-1:0]   res_sr_r;
  logic [WIDTH-1:0]   res_nxt_s;
  logic [WIDTH-1:0]   sum_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               carry_r;
  logic               carry_out_r;
  logic               prop_s;
  logic               gen0_s;
  logic               gen1_s;
  logic               bit_sum_s;
  logic               bit_carry_s;
  logic               last_bit_s;

  half_adder u_ha0 (
    .x (a_sr_r[0]),
    .y (b_sr_r[0]),
    .s (prop_s),
    .c (gen0_s)
  );

  half_adder u_ha1 (
    .x (prop_s),
    .y (carry_r),
    .s (bit_sum_s),
    .c (gen1_s)
  );

  assign bit_carry_s = gen0_s | gen1_s;
  assign res_nxt_s   = {bit_sum_s, res_sr_r[WIDTH-1:1]};
  assign last_bit_s  = (cnt_r == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; start is only honoured while idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, bit-serial datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r      <= '0;
      b_sr_r      <= '0;
      res_sr_r    <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sr_r  <= a;
            b_sr_r  <= b;
            carry_r <= 1'b0;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          res_sr_r <= res_nxt_s;
          carry_r  <= bit_carry_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          // Publish only on the final bit so partial sums stay hidden.
          if (last_bit_s) begin
            sum_r       <= res_nxt_s;
            carry_out_r <= bit_carry_s;
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign ready     = state_r[0];
  assign busy      = state_r[1];
  assign done      = state_r[2];
  assign sum       = sum_r;
  assign carry_out = carry_out_r;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder at WIDTH=8 and WIDTH=5,
// checked every cycle against a timeline model of each add.

module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start [2];
  logic [7:0] a     [2];
  logic [7:0] b     [2];
  logic       ready [2];
  logic       busy  [2];
  logic       done  [2];
  logic       co    [2];
  logic [7:0] sum8;
  logic [4:0] sum5;

  int checks = 0;
  int errors = 0;

  // Model: edges since acceptance (-1 = idle), held result, pending result.
  int wid   [2] = '{8, 5};
  int n_m   [2];
  int res_m [2];
  int pend_m[2];
  int acc_m [2];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a[0]), .b(b[0]),
    .ready(ready[0]), .busy(busy[0]), .done(done[0]), .sum(sum8), .carry_out(co[0])
  );

  serial_adder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a[1][4:0]), .b(b[1][4:0]),
    .ready(ready[1]), .busy(busy[1]), .done(done[1]), .sum(sum5), .carry_out(co[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference timeline: WIDTH busy cycles, one done cycle, then idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        n_m[i]   = -1;
        res_m[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int mask;
        mask = (1 << wid[i]) - 1;
        if (n_m[i] < 0) begin
          if (start[i] === 1'b1) begin
            n_m[i]    = 0;
            pend_m[i] = (int'(a[i]) & mask) + (int'(b[i]) & mask);
            acc_m[i]++;
          end
        end else if (n_m[i] < wid[i]) begin
          n_m[i]++;
          if (n_m[i] == wid[i]) res_m[i] = pend_m[i];
        end else begin
          n_m[i] = -1;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int act_sum;
      act_sum = (i == 0) ? int'(sum8) : int'(sum5);
      chk(i == 0 ? "ready8" : "ready5", int'(ready[i]), int'(n_m[i] < 0));
      chk(i == 0 ? "busy8" : "busy5", int'(busy[i]), int'(n_m[i] >= 0 && n_m[i] < wid[i]));
      chk(i == 0 ? "done8" : "done5", int'(done[i]), int'(n_m[i] == wid[i]));
      chk(i == 0 ? "sum8" : "sum5", act_sum, res_m[i] & ((1 << wid[i]) - 1));
      chk(i == 0 ? "cout8" : "cout5", int'(co[i]), (res_m[i] >> wid[i]) & 1);
      chk(i == 0 ? "onehot8" : "onehot5", int'(ready[i]) + int'(busy[i]) + int'(done[i]), 1);
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done[0] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) chk("done_timeout", cyc, 0);
  endtask

  task automatic do_add(input logic [7:0] x, input logic [7:0] y,
                        input int es, input int ec);
    int cyc;
    @(negedge clk);
    start[0] = 1'b1; a[0] = x; b[0] = y;
    @(negedge clk);
    start[0] = 1'b0; a[0] = 8'h00; b[0] = 8'h00;
    wait_done(cyc);
    chk("latency", cyc, 8);
    chk("lit_sum", int'(sum8), es);
    chk("lit_cout", int'(co[0]), ec);
  endtask

  initial begin
    int cyc;
    int base0;
    int guard;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; a[i] = 8'h00; b[i] = 8'h00; acc_m[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready[0]), 1);
    chk("rst_sum", int'(sum8), 0);
    rst_n = 1'b1;

    do_add(8'h00, 8'h00, 8'h00, 0);
    do_add(8'hFF, 8'h01, 8'h00, 1);
    do_add(8'hA5, 8'h5A, 8'hFF, 0);

    // Start held through DONE: second add re-accepted in the first idle cycle.
    @(negedge clk);
    start[0] = 1'b1; a[0] = 8'hFF; b[0] = 8'hFF;
    @(negedge clk);
    a[0] = 8'h01; b[0] = 8'h02;
    wait_done(cyc);
    chk("b2b1_sum", int'(sum8), 8'hFE);
    chk("b2b1_cout", int'(co[0]), 1);
    @(negedge clk);
    chk("b2b_ready", int'(ready[0]), 1);
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(cyc);
    chk("b2b2_sum", int'(sum8), 8'h03);
    chk("b2b2_cout", int'(co[0]), 0);

    // Start pulsed mid-run is ignored; result stays held until done.
    @(negedge clk);
    start[0] = 1'b1; a[0] = 8'h0F; b[0] = 8'h01;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    start[0] = 1'b1; a[0] = 8'hF0; b[0] = 8'hF0;
    chk("hold_sum", int'(sum8), 8'h03);
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(cyc);
    chk("ign_sum", int'(sum8), 8'h10);
    chk("ign_cout", int'(co[0]), 0);

    // Asynchronous reset mid-run.
    @(negedge clk);
    start[0] = 1'b1; a[0] = 8'hFF; b[0] = 8'hFF;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", int'(ready[0]), 1);
    chk("arst_busy", int'(busy[0]), 0);
    chk("arst_sum", int'(sum8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_add(8'h12, 8'h34, 8'h46, 0);

    // Randomised phase on both widths.
    base0 = acc_m[0];
    guard = 0;
    while ((acc_m[0] - base0 < 200 || acc_m[1] < 200) && guard < 20000) begin
      @(negedge clk);
      guard++;
      for (int i = 0; i < 2; i++) begin
        start[i] = ($urandom_range(0, 3) != 0);
        a[i]     = 8'($urandom);
        b[i]     = 8'($urandom);
      end
    end
    if (guard >= 20000) chk("random_timeout", guard, 0);
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
